prach_deframer: RTL and testbench
=================================

Name: prach_deframer

Overview:
- Receive-side counterpart of the PRACH framer. Accepts ORAN U-plane PRACH packets as a 64-bit Avalon-ST stream plus a per-packet sideband header vector, all in one clock domain.
- Each packet's IQ payload is unpacked to one 16+16-bit sample per cycle. The header is re-emitted as a 120-bit vector aligned with a sync pulse.
- Packets are length-checked and filtered, with error and statistics outputs.
- Sits between the receive CDC and the PRACH DSP chain.

Parameters:
- NUM_SAMPLES, 864, IQ samples per packet. Must be even and at least 2; this is elaboration-checked.
- FILTER_IDX, 4'd1, filterIndex value accepted. Packets with any other value are dropped.

Ports:
- clk_dsp  in  1  clock.
- rst_dsp_n  in  1  asynchronous active-low reset.
- avst_sink_data  in  64  two samples per beat. Bits [31:16] = I0, [15:0] = Q0, [63:48] = I1, [47:32] = Q1. Sample 0 goes out first.
- avst_sink_valid  in  1  beat valid.
- avst_sink_startofpacket  in  1  first beat.
- avst_sink_endofpacket  in  1  last beat.
- avst_sink_ready  out  1  beat accepted when valid && ready.
- rx_u_hdr  in  120  sideband header, sampled on the SOP beat.
  - Layout, MSB first: size16, pc_id16, seq_id16, dataDirection1, payloadVersion3, filterIndex4, frameId8, subframeId4, slotID6, symbolid6, sectionId12, rb1, symInc1, startPrb10, numPrb8, udCompHdr8.
- dout_dr  out  16  sample I.
- dout_di  out  16  sample Q.
- dout_dv  out  1  sample valid.
- sync_out  out  1  one-cycle pulse coincident with the first sample of each accepted packet.
- hdr_out  out  120  header of the current packet. Same layout as rx_u_hdr. Updated on the sync_out cycle and held until the next sync_out.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  error type, qualified by err_valid. 1 = SHORT, 2 = LONG, 3 = NOSOP.
- pkt_cnt  out  16  count of accepted packets. Wraps.
- drop_cnt  out  16  count of filtered packets. Wraps.

Behaviour:
- Reset values: all outputs are 0 except avst_sink_ready. avst_sink_ready is 0 while rst_dsp_n is low and 1 from the first cycle after release (IDLE, pend = 0).
- States:
  - IDLE: waiting for SOP.
  - PAYLOAD: unpacking an accepted packet.
  - DROP: discarding beats until EOP.
- Ready rule: avst_sink_ready = !pend. pend is set when a PAYLOAD beat is accepted and cleared on the next edge. Sustained throughput is 1 beat per 2 cycles, giving continuous samples.
- Unpack on an accepted PAYLOAD beat:
  - Next edge: dout <= sample0, hold <= sample1, pend <= 1.
  - Following edge: dout <= hold, pend <= 0.
  - Latency from beat acceptance to sample0 on dout is 1 cycle.
  - dout_dv is high on both sample cycles; dr/di are don't-care when dv is low.
- IDLE + SOP beat:
  - If dataDirection == 0 and filterIndex == FILTER_IDX: the beat is the first PAYLOAD beat. Latch the header. On the sample0 cycle, sync_out = 1, hdr_out updates and pkt_cnt increments.
  - Otherwise: drop_cnt increments and no error is raised. Go to DROP, or stay in IDLE if the beat also carries EOP.
- IDLE + beat without SOP: err NOSOP. Go to DROP, or stay in IDLE if the beat carries EOP.
- Beat counter: counts accepted beats 1..NUM_SAMPLES/2.
  - EOP exactly on beat NUM_SAMPLES/2: normal completion, go to IDLE.
  - EOP earlier: samples already output stand, the EOP beat's samples are output, then err SHORT and go to IDLE.
  - Beat NUM_SAMPLES/2 arrives without EOP: its samples are output, then err LONG and go to DROP. All further beats are discarded up to and including EOP.
- SOP while in PAYLOAD:
  - Raise err SHORT for the old packet.
  - The SOP beat starts a new packet: header check, then sync or drop as in IDLE.
- DROP: ready stays 1 and no samples are output. EOP returns to IDLE. SOP inside DROP is treated as a fresh packet.
- Error timing: err_valid pulses on the edge after the causing beat. At most one error per beat; SHORT takes priority.
- Reset mid-packet: state returns to IDLE, pend clears and the partial packet is lost. The first post-reset non-SOP beat raises NOSOP.
- Counters wrap from 0xFFFF to 0 with no saturation.

Decomposition:
- Package prach_pkg holds:
  - the prach_uhdr_t packed struct for the 120-bit layout;
  - field offset constants;
  - the err_code enum (ERR_NONE, ERR_SHORT, ERR_LONG, ERR_NOSOP);
  - the NUM_SAMPLES default.
- One sub-module, prach_deframer_unpack: the 64-to-32 width converter holding the pend/hold registers and the ready logic. The FSM, counters and header logic stay in the top.

Test Plan:
- Nominal packet:
  - Stimulus: one 432-beat packet (NUM_SAMPLES 864) with filterIndex 1, dataDirection 0, and data words equal to the sample index.
  - Required: 864 consecutive dout_dv cycles in order 0..863; sync_out on the first sample; hdr_out equal to the input header; pkt_cnt = 1; no err_valid.
- Back-to-back:
  - Stimulus: two packets with valid held high throughout and seq_id 5 then 6.
  - Required: ready toggles 1/0; 1728 samples with no dv gap; two sync pulses 864 cycles apart; hdr_out seq_id 5 then 6.
- Short packet:
  - Stimulus: EOP on beat 100.
  - Required: 200 samples; err_valid with err_code 1; next packet accepted normally.
- Long packet:
  - Stimulus: 440 beats with EOP on beat 440.
  - Required: exactly 864 samples; err_code 2 once; 8 beats dropped with ready still high.
- Filter and NOSOP:
  - Stimulus: SOP packet with filterIndex 3, then a headerless 4-beat fragment ending in EOP.
  - Required: drop_cnt = 1 and no error for the filtered packet; one err_code 3 for the fragment; no dout_dv for either.
- Reset mid-packet:
  - Stimulus: assert rst_dsp_n low at beat 50.
  - Required: all outputs go to 0 asynchronously; after release ready = 1; a new SOP packet is output complete with pkt_cnt = 1.

Source files
------------

// File: rtl/prach_deframer_pkg.sv
// Shared types and constants for the PRACH U-plane deframer: header layout,
// error codes and FSM state encoding.
package prach_pkg;

  localparam int PRACH_NUM_SAMPLES = 864;
  localparam int SAMPLE_W          = 16;
  localparam int HDR_W             = 120;

  typedef struct packed {
    logic [15:0] size;
    logic [15:0] pc_id;
    logic [15:0] seq_id;
    logic        data_direction;
    logic [2:0]  payload_version;
    logic [3:0]  filter_index;
    logic [7:0]  frame_id;
    logic [3:0]  subframe_id;
    logic [5:0]  slot_id;
    logic [5:0]  symbol_id;
    logic [11:0] section_id;
    logic        rb;
    logic        sym_inc;
    logic [9:0]  start_prb;
    logic [7:0]  num_prb;
    logic [7:0]  ud_comp_hdr;
  } prach_uhdr_t;

  // Bit offsets (LSB) of each field inside the 120-bit header vector.
  localparam int OFF_UD_COMP_HDR     = 0;
  localparam int OFF_NUM_PRB         = 8;
  localparam int OFF_START_PRB       = 16;
  localparam int OFF_SYM_INC         = 26;
  localparam int OFF_RB              = 27;
  localparam int OFF_SECTION_ID      = 28;
  localparam int OFF_SYMBOL_ID       = 40;
  localparam int OFF_SLOT_ID         = 46;
  localparam int OFF_SUBFRAME_ID     = 52;
  localparam int OFF_FRAME_ID        = 56;
  localparam int OFF_FILTER_INDEX    = 64;
  localparam int OFF_PAYLOAD_VERSION = 68;
  localparam int OFF_DATA_DIRECTION  = 71;
  localparam int OFF_SEQ_ID          = 72;
  localparam int OFF_PC_ID           = 88;
  localparam int OFF_SIZE            = 104;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_NOSOP = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // Uplink PRACH packets with the configured filter index are the only ones kept.
  function automatic logic hdr_accept(input prach_uhdr_t hdr, input logic [3:0] filter_idx);
    return (hdr.data_direction == 1'b0) && (hdr.filter_index == filter_idx);
  endfunction

endpackage

// File: rtl/prach_deframer_unpack.sv
// 64-to-32 width converter: one two-sample beat in, one IQ sample per cycle out.
// A beat is only taken when the previous beat's second sample has been emitted.
module prach_deframer_unpack
  import prach_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           beat_data,
  input  logic                  load,
  output logic                  ready,
  output logic [SAMPLE_W-1:0]   dout_dr,
  output logic [SAMPLE_W-1:0]   dout_di,
  output logic                  dout_dv
);

  logic [2*SAMPLE_W-1:0] hold_r;
  logic [2*SAMPLE_W-1:0] dout_r;
  logic                  pend_r;
  logic                  dv_r;
  logic                  ready_r;

  // ready_r mirrors !pend but stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r  <= 32'd0;
      dout_r  <= 32'd0;
      pend_r  <= 1'b0;
      dv_r    <= 1'b0;
      ready_r <= 1'b0;
    end else if (load) begin
      dout_r  <= beat_data[31:0];
      hold_r  <= beat_data[63:32];
      pend_r  <= 1'b1;
      dv_r    <= 1'b1;
      ready_r <= 1'b0;
    end else if (pend_r) begin
      dout_r  <= hold_r;
      pend_r  <= 1'b0;
      dv_r    <= 1'b1;
      ready_r <= 1'b1;
    end else begin
      dv_r    <= 1'b0;
      ready_r <= 1'b1;
    end
  end

  assign ready   = ready_r;
  assign dout_dr = dout_r[2*SAMPLE_W-1:SAMPLE_W];
  assign dout_di = dout_r[SAMPLE_W-1:0];
  assign dout_dv = dv_r;

endmodule

// File: rtl/prach_deframer.sv
// PRACH U-plane deframer: header filtering, length checking and statistics
// around the beat-to-sample unpacker.
module prach_deframer
  import prach_pkg::*;
#(
  parameter int         NUM_SAMPLES = PRACH_NUM_SAMPLES,
  parameter logic [3:0] FILTER_IDX  = 4'd1
) (
  input  logic             clk_dsp,
  input  logic             rst_dsp_n,
  input  logic [63:0]      avst_sink_data,
  input  logic             avst_sink_valid,
  input  logic             avst_sink_startofpacket,
  input  logic             avst_sink_endofpacket,
  output logic             avst_sink_ready,
  input  logic [HDR_W-1:0] rx_u_hdr,
  output logic [15:0]      dout_dr,
  output logic [15:0]      dout_di,
  output logic             dout_dv,
  output logic             sync_out,
  output logic [HDR_W-1:0] hdr_out,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int            HALF       = NUM_SAMPLES / 2;
  localparam int            CW         = (HALF > 1) ? $clog2(HALF + 1) : 1;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(HALF);
  localparam logic [CW-1:0] FIRST_BEAT = CW'(1);

  if (NUM_SAMPLES < 2 || (NUM_SAMPLES % 2) != 0) begin : g_bad_num_samples
    $error("prach_deframer: NUM_SAMPLES must be even and at least 2");
  end

  state_t        state_r, state_nx;
  logic [CW-1:0] beat_cnt_r, beat_cnt_nx, beat_num_s;
  err_code_t     err_nx, pay_err_s, err_code_r;
  state_t        pay_state_s;
  prach_uhdr_t   hdr_in_s, hdr_r;
  logic          accept_s, ready_s, start_s, load_s, drop_s, last_s, eop_s;
  logic          sync_r, err_valid_r;
  logic [15:0]   pkt_cnt_r, drop_cnt_r;

  assign hdr_in_s   = rx_u_hdr;
  assign eop_s      = avst_sink_endofpacket;
  assign accept_s   = avst_sink_valid && ready_s;
  assign beat_num_s = avst_sink_startofpacket ? FIRST_BEAT : beat_cnt_r + FIRST_BEAT;
  assign last_s     = (beat_num_s == LAST_BEAT);

  // Outcome of a payload beat, shared by the SOP and continuation paths.
  assign pay_state_s = eop_s ? ST_IDLE : (last_s ? ST_DROP : ST_PAYLOAD);
  assign pay_err_s   = (eop_s && !last_s) ? ERR_SHORT :
                       ((!eop_s && last_s) ? ERR_LONG : ERR_NONE);

  // Next-state, error and counter-strobe decode for each accepted beat.
  always_comb begin
    state_nx    = state_r;
    beat_cnt_nx = beat_cnt_r;
    err_nx      = ERR_NONE;
    start_s     = 1'b0;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    if (accept_s) begin
      if (avst_sink_startofpacket) begin
        if (hdr_accept(hdr_in_s, FILTER_IDX)) begin
          start_s     = 1'b1;
          load_s      = 1'b1;
          beat_cnt_nx = beat_num_s;
          state_nx    = pay_state_s;
          err_nx      = pay_err_s;
        end else begin
          drop_s   = 1'b1;
          state_nx = eop_s ? ST_IDLE : ST_DROP;
        end
        // A new SOP truncates any packet in flight; SHORT wins over other errors.
        if (state_r == ST_PAYLOAD) begin
          err_nx = ERR_SHORT;
        end else begin
          err_nx = err_nx;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            err_nx   = ERR_NOSOP;
            state_nx = eop_s ? ST_IDLE : ST_DROP;
          end
          ST_PAYLOAD: begin
            load_s      = 1'b1;
            beat_cnt_nx = beat_num_s;
            state_nx    = pay_state_s;
            err_nx      = pay_err_s;
          end
          ST_DROP: begin
            state_nx = eop_s ? ST_IDLE : ST_DROP;
          end
          default: begin
            state_nx = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_nx = state_r;
    end
  end

  // FSM state, header capture, error pulse and statistics registers.
  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= '0;
      hdr_r       <= '0;
      sync_r      <= 1'b0;
      err_valid_r <= 1'b0;
      err_code_r  <= ERR_NONE;
      pkt_cnt_r   <= 16'd0;
      drop_cnt_r  <= 16'd0;
    end else begin
      state_r     <= state_nx;
      beat_cnt_r  <= beat_cnt_nx;
      sync_r      <= start_s;
      err_valid_r <= (err_nx != ERR_NONE);
      err_code_r  <= err_nx;
      hdr_r       <= start_s ? hdr_in_s : hdr_r;
      pkt_cnt_r   <= pkt_cnt_r + {15'd0, start_s};
      drop_cnt_r  <= drop_cnt_r + {15'd0, drop_s};
    end
  end

  prach_deframer_unpack u_unpack (
    .clk       (clk_dsp),
    .rst_n     (rst_dsp_n),
    .beat_data (avst_sink_data),
    .load      (load_s),
    .ready     (ready_s),
    .dout_dr   (dout_dr),
    .dout_di   (dout_di),
    .dout_dv   (dout_dv)
  );

  assign avst_sink_ready = ready_s;
  assign sync_out        = sync_r;
  assign hdr_out         = hdr_r;
  assign err_valid       = err_valid_r;
  assign err_code        = err_code_r;
  assign pkt_cnt         = pkt_cnt_r;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_prach_deframer.sv
// Directed self-checking bench for prach_deframer: nominal, back-to-back,
// short, long, filtered, headerless and mid-packet reset scenarios.
module tb_prach_deframer;
  import prach_pkg::*;

  localparam int NS   = 864;
  localparam int HALF = NS / 2;

  logic              clk_dsp = 1'b0;
  logic              rst_dsp_n = 1'b0;
  logic [63:0]       avst_sink_data = 64'd0;
  logic              avst_sink_valid = 1'b0;
  logic              avst_sink_startofpacket = 1'b0;
  logic              avst_sink_endofpacket = 1'b0;
  logic              avst_sink_ready;
  logic [HDR_W-1:0]  rx_u_hdr = '0;
  logic [15:0]       dout_dr, dout_di;
  logic              dout_dv, sync_out, err_valid;
  logic [HDR_W-1:0]  hdr_out;
  logic [1:0]        err_code;
  logic [15:0]       pkt_cnt, drop_cnt;

  always #5 clk_dsp = ~clk_dsp;

  prach_deframer #(.NUM_SAMPLES(NS), .FILTER_IDX(4'd1)) dut (
    .clk_dsp                 (clk_dsp),
    .rst_dsp_n               (rst_dsp_n),
    .avst_sink_data          (avst_sink_data),
    .avst_sink_valid         (avst_sink_valid),
    .avst_sink_startofpacket (avst_sink_startofpacket),
    .avst_sink_endofpacket   (avst_sink_endofpacket),
    .avst_sink_ready         (avst_sink_ready),
    .rx_u_hdr                (rx_u_hdr),
    .dout_dr                 (dout_dr),
    .dout_di                 (dout_di),
    .dout_dv                 (dout_dv),
    .sync_out                (sync_out),
    .hdr_out                 (hdr_out),
    .err_valid               (err_valid),
    .err_code                (err_code),
    .pkt_cnt                 (pkt_cnt),
    .drop_cnt                (drop_cnt)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Stream monitor: samples are expected as I = index within packet, Q = ~I.
  int          cyc = 0, dv_total = 0, dv_falls = 0, order_err = 0;
  int          sync_total = 0, sync_prev_cyc = 0, sync_last_cyc = 0, err_total = 0;
  int          err_by_code [4] = '{0, 0, 0, 0};
  logic        dv_q = 1'b0;
  logic [15:0] prev_i = 16'd0;
  prach_uhdr_t hdr_prev = '0, hdr_last = '0;

  always @(negedge clk_dsp) begin
    cyc  <= cyc + 1;
    dv_q <= dout_dv;
    if (dout_dv) begin
      dv_total <= dv_total + 1;
      prev_i   <= dout_dr;
    end
    order_err <= order_err
               + int'(dout_dv && (dout_di !== ~dout_dr))
               + int'(dout_dv && !sync_out && (dout_dr !== prev_i + 16'd1))
               + int'(sync_out && (!dout_dv || dout_dr !== 16'd0));
    if (dv_q && !dout_dv) dv_falls <= dv_falls + 1;
    if (sync_out) begin
      sync_total    <= sync_total + 1;
      sync_prev_cyc <= sync_last_cyc;
      sync_last_cyc <= cyc;
      hdr_prev      <= hdr_last;
      hdr_last      <= hdr_out;
    end
    if (err_valid) begin
      err_total              <= err_total + 1;
      err_by_code[err_code]  <= err_by_code[err_code] + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic prach_uhdr_t make_hdr(input logic [15:0] seq, input logic dir, input logic [3:0] filt);
    prach_uhdr_t h;
    h.size = 16'd3472;       h.pc_id = 16'h1234;       h.seq_id = seq;
    h.data_direction = dir;  h.payload_version = 3'd1; h.filter_index = filt;
    h.frame_id = 8'h5A;      h.subframe_id = 4'h3;     h.slot_id = 6'd9;
    h.symbol_id = 6'd2;      h.section_id = 12'hABC;   h.rb = 1'b0;
    h.sym_inc = 1'b1;        h.start_prb = 10'd17;     h.num_prb = 8'd72;
    h.ud_comp_hdr = 8'h00;
    return h;
  endfunction

  function automatic logic [63:0] beat_word(input int k);
    logic [15:0] a, b;
    a = 16'(k);
    b = 16'(k + 1);
    return {b, ~b, a, ~a};
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [63:0] d, input logic s, input logic e, output int w);
    avst_sink_data = d;
    avst_sink_startofpacket = s;
    avst_sink_endofpacket = e;
    avst_sink_valid = 1'b1;
    w = 0;
    while (avst_sink_ready !== 1'b1 && w < 50) begin
      @(negedge clk_dsp);
      w++;
    end
    if (w >= 50) chk("ready_timeout", {127'd0, avst_sink_ready}, 128'd1);
    @(negedge clk_dsp);
  endtask

  task automatic send_pkt(input prach_uhdr_t h, input int nbeats, input int eop_at,
                          input logic use_sop, input logic chk_lat,
                          output int tot_w, output int late_w);
    int w;
    rx_u_hdr = h;
    tot_w = 0;
    late_w = 0;
    for (int b = 1; b <= nbeats; b++) begin
      send_beat(beat_word(2 * (b - 1)), use_sop && (b == 1), b == eop_at, w);
      tot_w += w;
      if (b > HALF + 1) late_w += w;
      if (chk_lat && b == 1)
        chk("first_sample_latency", {110'd0, sync_out, dout_dv, dout_dr}, {110'd0, 1'b1, 1'b1, 16'd0});
    end
  endtask

  task automatic idle_cycles(input int n);
    avst_sink_valid = 1'b0;
    avst_sink_startofpacket = 1'b0;
    avst_sink_endofpacket = 1'b0;
    repeat (n) @(negedge clk_dsp);
  endtask

  int tw, lw, tw2, lw2;
  int s_dv, s_falls, s_sync, s_err, s_ord, s_short, s_long, s_nosop;

  task automatic snap();
    s_dv = dv_total;  s_falls = dv_falls;  s_sync = sync_total;  s_err = err_total;
    s_ord = order_err;  s_short = err_by_code[1];  s_long = err_by_code[2];
    s_nosop = err_by_code[3];
  endtask

  initial begin
    prach_uhdr_t h;

    // Reset state
    repeat (3) @(negedge clk_dsp);
    chk("rst_ready", {127'd0, avst_sink_ready}, 128'd0);
    chk("rst_outputs", {90'd0, dout_dv, sync_out, err_valid, err_code, pkt_cnt, drop_cnt}, 128'd0);
    chk("rst_hdr", {8'd0, hdr_out}, 128'd0);
    rst_dsp_n = 1'b1;
    @(negedge clk_dsp);
    chk("ready_after_release", {127'd0, avst_sink_ready}, 128'd1);

    // Nominal packet
    h = make_hdr(16'd1, 1'b0, 4'd1);
    snap();
    send_pkt(h, HALF, HALF, 1'b1, 1'b1, tw, lw);
    idle_cycles(6);
    chk("nom_samples", 128'(dv_total - s_dv), 128'(NS));
    chk("nom_order", 128'(order_err - s_ord), 128'd0);
    chk("nom_dv_gaps", 128'(dv_falls - s_falls), 128'd1);
    chk("nom_sync", 128'(sync_total - s_sync), 128'd1);
    chk("nom_hdr_out", {8'd0, hdr_out}, {8'd0, h});
    chk("nom_hdr_at_sync", {8'd0, hdr_last}, {8'd0, h});
    chk("nom_pkt_cnt", {112'd0, pkt_cnt}, 128'd1);
    chk("nom_no_err", 128'(err_total - s_err), 128'd0);

    // Back-to-back with valid held high
    snap();
    send_pkt(make_hdr(16'd5, 1'b0, 4'd1), HALF, HALF, 1'b1, 1'b1, tw, lw);
    send_pkt(make_hdr(16'd6, 1'b0, 4'd1), HALF, HALF, 1'b1, 1'b1, tw2, lw2);
    idle_cycles(6);
    chk("b2b_ready_toggle_waits", 128'(tw + tw2), 128'(2 * HALF - 1));
    chk("b2b_samples", 128'(dv_total - s_dv), 128'(2 * NS));
    chk("b2b_no_gap", 128'(dv_falls - s_falls), 128'd1);
    chk("b2b_sync_count", 128'(sync_total - s_sync), 128'd2);
    chk("b2b_sync_spacing", 128'(sync_last_cyc - sync_prev_cyc), 128'(NS));
    chk("b2b_seq_first", {112'd0, hdr_prev.seq_id}, 128'd5);
    chk("b2b_seq_second", {112'd0, hdr_last.seq_id}, 128'd6);
    chk("b2b_order", 128'(order_err - s_ord), 128'd0);
    chk("b2b_pkt_cnt", {112'd0, pkt_cnt}, 128'd3);

    // Short packet then a normal one
    snap();
    send_pkt(make_hdr(16'd8, 1'b0, 4'd1), 100, 100, 1'b1, 1'b1, tw, lw);
    idle_cycles(6);
    chk("short_samples", 128'(dv_total - s_dv), 128'd200);
    chk("short_err_code1", 128'(err_by_code[1] - s_short), 128'd1);
    chk("short_err_total", 128'(err_total - s_err), 128'd1);
    snap();
    send_pkt(make_hdr(16'd9, 1'b0, 4'd1), HALF, HALF, 1'b1, 1'b1, tw, lw);
    idle_cycles(6);
    chk("after_short_samples", 128'(dv_total - s_dv), 128'(NS));
    chk("after_short_no_err", 128'(err_total - s_err), 128'd0);
    chk("after_short_pkt_cnt", {112'd0, pkt_cnt}, 128'd5);
    chk("short_order", 128'(order_err - s_ord), 128'd0);

    // Long packet: 440 beats
    snap();
    send_pkt(make_hdr(16'd10, 1'b0, 4'd1), 440, 440, 1'b1, 1'b1, tw, lw);
    idle_cycles(6);
    chk("long_samples", 128'(dv_total - s_dv), 128'(NS));
    chk("long_err_code2", 128'(err_by_code[2] - s_long), 128'd1);
    chk("long_err_total", 128'(err_total - s_err), 128'd1);
    chk("long_drop_ready_high", 128'(lw), 128'd0);
    chk("long_pkt_cnt", {112'd0, pkt_cnt}, 128'd6);

    // Filtered packet, then headerless fragment
    snap();
    send_pkt(make_hdr(16'd11, 1'b0, 4'd3), 6, 6, 1'b1, 1'b0, tw, lw);
    idle_cycles(4);
    chk("filt_drop_cnt", {112'd0, drop_cnt}, 128'd1);
    chk("filt_no_err", 128'(err_total - s_err), 128'd0);
    chk("filt_no_dv", 128'(dv_total - s_dv), 128'd0);
    snap();
    send_pkt(make_hdr(16'd12, 1'b0, 4'd1), 4, 4, 1'b0, 1'b0, tw, lw);
    idle_cycles(4);
    chk("nosop_err_code3", 128'(err_by_code[3] - s_nosop), 128'd1);
    chk("nosop_err_total", 128'(err_total - s_err), 128'd1);
    chk("nosop_no_dv", 128'(dv_total - s_dv), 128'd0);
    chk("nosop_pkt_cnt", {112'd0, pkt_cnt}, 128'd6);

    // Reset mid-packet
    send_pkt(make_hdr(16'd13, 1'b0, 4'd1), 49, 0, 1'b1, 1'b1, tw, lw);
    chk("pre_rst_dv", {127'd0, dout_dv}, 128'd1);
    chk("pre_rst_pkt_cnt", {112'd0, pkt_cnt}, 128'd7);
    avst_sink_valid = 1'b0;
    rst_dsp_n = 1'b0;
    #1;
    chk("async_rst_ready", {127'd0, avst_sink_ready}, 128'd0);
    chk("async_rst_outputs", {58'd0, dout_dr, dout_di, dout_dv, sync_out, err_valid, err_code, pkt_cnt, drop_cnt}, 128'd0);
    chk("async_rst_hdr", {8'd0, hdr_out}, 128'd0);
    repeat (2) @(negedge clk_dsp);
    rst_dsp_n = 1'b1;
    @(negedge clk_dsp);
    chk("post_rst_ready", {127'd0, avst_sink_ready}, 128'd1);
    snap();
    send_pkt(make_hdr(16'd14, 1'b0, 4'd1), HALF, HALF, 1'b1, 1'b1, tw, lw);
    idle_cycles(6);
    chk("post_rst_samples", 128'(dv_total - s_dv), 128'(NS));
    chk("post_rst_pkt_cnt", {112'd0, pkt_cnt}, 128'd1);
    chk("post_rst_order", 128'(order_err - s_ord), 128'd0);
    chk("post_rst_no_err", 128'(err_total - s_err), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
